chip_dac_seq: RTL and testbench

- Parametrised successor to the single-DAC chip programming FSM.
- Holds a per-channel DAC level table written by the host and runs the chip's reset preamble once per start.
- Then streams one serial frame per enabled channel over chip_rst/chip_clk/chip_data_in, with an optional continuous-refresh mode.
- Sits between the FPGA host register interface and the chip-under-test pins.

---
 rtl/chip_dac_seq.sv | 215 +++++++++++++++++++++
 tb/tb_chip_dac_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_dac_seq.sv
// chip_dac_seq: DAC level table plus serial programming sequencer for the chip.
// Ports: clk/rst, table write (wr_*), ch_mask/refresh_en/start/busy/done/cur_ch, chip pins.
module chip_dac_seq #(
  parameter int CLK_DIV   = 4000,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int N_CH      = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              refresh_en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_ch,
  output logic              chip_rst,
  output logic              chip_clk,
  output logic              chip_data_in
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SEP, S_ADDR, S_DATA, S_END
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [7:0]        idx, idx_n;
  logic [ADDR_W-1:0] cur_ch_n;
  logic [N_CH-1:0]   mask_q, mask_n;
  logic [DATA_W-1:0] level, level_n;
  logic              busy_n, done_n, clk_n;
  logic              prst_n, pdat_n;
  logic              last, go_sep, go_end;
  logic [ADDR_W:0]   sel;
  logic [DATA_W-1:0] tbl [N_CH];

  // Lowest enabled channel at or above 'from'; MSB of result = found.
  function automatic logic [ADDR_W:0] pick(
    input logic [N_CH-1:0] m,
    input int              from
  );
    logic [ADDR_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, ADDR_W'(i)};
    return r;
  endfunction

  function automatic logic abit(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        i
  );
    logic [ADDR_W-1:0] s;
    s = a >> ((MSB_FIRST != 0) ? (ADDR_W - 1 - int'(i)) : int'(i));
    return s[0];
  endfunction

  function automatic logic dbit(
    input logic [DATA_W-1:0] d,
    input logic [7:0]        i
  );
    logic [DATA_W-1:0] s;
    s = d >> ((MSB_FIRST != 0) ? (DATA_W - 1 - int'(i)) : int'(i));
    return s[0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) tbl[i] <= '0;
    end else if (wr_en &&
                 ({1'b0, wr_addr} < (ADDR_W + 1)'(N_CH))) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      cur_ch       <= '0;
      mask_q       <= '0;
      level        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      chip_clk     <= 1'b0;
      chip_rst     <= 1'b0;
      chip_data_in <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      cur_ch       <= cur_ch_n;
      mask_q       <= mask_n;
      level        <= level_n;
      busy         <= busy_n;
      done         <= done_n;
      chip_clk     <= clk_n;
      chip_rst     <= prst_n;
      chip_data_in <= pdat_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    cur_ch_n = cur_ch;
    mask_n   = mask_q;
    level_n  = level;
    busy_n   = busy;
    done_n   = 1'b0;
    clk_n    = 1'b0;
    prst_n   = chip_rst;
    pdat_n   = chip_data_in;
    go_sep   = 1'b0;
    go_end   = 1'b0;
    sel      = '0;
    last     = (cnt == CW'(CLK_DIV - 1));

    if (state == S_IDLE) begin
      if (start) begin
        state_n = S_PRE;
        idx_n   = '0;
        cnt_n   = '0;
        busy_n  = 1'b1;
        mask_n  = ch_mask;
        prst_n  = 1'b0;
        pdat_n  = 1'b0;
      end
    end else begin
      cnt_n  = last ? '0 : cnt + CW'(1);
      clk_n  = (cnt_n >= CW'(HALF));
      // Registered, so it is high during the last count of END.
      done_n = (state == S_END) && (cnt == CW'(CLK_DIV - 2));
      if (last) begin
        unique case (state)
          S_PRE: begin
            if (idx == 8'd3) begin
              sel    = pick(mask_q, 0);
              go_sep = sel[ADDR_W];
              go_end = !sel[ADDR_W];
            end else begin
              idx_n  = idx + 8'd1;
              prst_n = (idx_n == 8'd3);
              pdat_n = (idx_n >= 8'd2);
            end
          end
          S_SEP: begin
            state_n = S_ADDR;
            idx_n   = '0;
            prst_n  = 1'b1;
            pdat_n  = abit(cur_ch, 8'd0);
          end
          S_ADDR: begin
            if (idx == 8'(ADDR_W - 1)) begin
              state_n = S_DATA;
              idx_n   = '0;
              pdat_n  = dbit(level, 8'd0);
            end else begin
              idx_n  = idx + 8'd1;
              pdat_n = abit(cur_ch, idx_n);
            end
          end
          S_DATA: begin
            if (idx == 8'(DATA_W - 1)) begin
              sel    = pick(mask_q, int'(cur_ch) + 1);
              go_sep = sel[ADDR_W];
              go_end = !sel[ADDR_W];
            end else begin
              idx_n  = idx + 8'd1;
              pdat_n = dbit(level, idx_n);
            end
          end
          S_END: begin
            if (refresh_en && (|ch_mask)) begin
              mask_n = ch_mask;
              sel    = pick(ch_mask, 0);
              go_sep = 1'b1;
            end else begin
              state_n  = S_IDLE;
              busy_n   = 1'b0;
              cur_ch_n = '0;
            end
          end
          default: ;
        endcase
      end
    end

    if (go_sep) begin
      state_n  = S_SEP;
      idx_n    = '0;
      cur_ch_n = sel[ADDR_W-1:0];
      level_n  = tbl[sel[ADDR_W-1:0]];
      prst_n   = 1'b1;
      pdat_n   = 1'b0;
    end
    if (go_end) begin
      state_n = S_END;
      idx_n   = '0;
      prst_n  = 1'b1;
      pdat_n  = 1'b1;
    end
  end

endmodule

// File: tb/tb_chip_dac_seq.sv
// tb_chip_dac_seq: directed bench for chip_dac_seq, LSB- and MSB-first copies.
// Pin streams are captured at chip_clk rises and compared to a frame model.
module tb_chip_dac_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] ch_mask;
  logic       refresh_en;
  logic       start;

  logic       busy, done, crst, cclk, cdat;
  logic [2:0] cur_ch;
  logic       busy_m, done_m, crst_m, cclk_m, cdat_m;
  logic [2:0] cur_ch_m;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] q0[$], q1[$], e0[$], e1[$];
  logic [2:0] cq[$];

  int bc, nd, da, ra;

  chip_dac_seq #(
    .CLK_DIV(8), .ADDR_W(3), .DATA_W(8), .N_CH(8), .MSB_FIRST(0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ch_mask(ch_mask), .refresh_en(refresh_en),
    .start(start), .busy(busy), .done(done), .cur_ch(cur_ch),
    .chip_rst(crst), .chip_clk(cclk), .chip_data_in(cdat)
  );

  chip_dac_seq #(
    .CLK_DIV(8), .ADDR_W(3), .DATA_W(8), .N_CH(8), .MSB_FIRST(1)
  ) dut_m (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ch_mask(ch_mask), .refresh_en(refresh_en),
    .start(start), .busy(busy_m), .done(done_m), .cur_ch(cur_ch_m),
    .chip_rst(crst_m), .chip_clk(cclk_m), .chip_data_in(cdat_m)
  );

  always #5 clk = ~clk;

  always @(posedge cclk) begin
    q0.push_back({crst, cdat});
    cq.push_back(cur_ch);
  end

  always @(posedge cclk_m) q1.push_back({crst_m, cdat_m});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bitof(input logic [7:0] v, input int i);
    logic [7:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic void m_pre();
    e0.push_back(2'b00); e0.push_back(2'b00);
    e0.push_back(2'b01); e0.push_back(2'b11);
    e1.push_back(2'b00); e1.push_back(2'b00);
    e1.push_back(2'b01); e1.push_back(2'b11);
  endfunction

  function automatic void m_frame(input int c, input logic [7:0] v);
    logic [7:0] a;
    a = 8'(c);
    e0.push_back(2'b10);
    e1.push_back(2'b10);
    for (int i = 0; i < 3; i++) begin
      e0.push_back({1'b1, bitof(a, i)});
      e1.push_back({1'b1, bitof(a, 2 - i)});
    end
    for (int i = 0; i < 8; i++) begin
      e0.push_back({1'b1, bitof(v, i)});
      e1.push_back({1'b1, bitof(v, 7 - i)});
    end
  endfunction

  function automatic void m_end();
    e0.push_back(2'b11);
    e1.push_back(2'b11);
  endfunction

  task automatic clr();
    q0.delete(); q1.delete(); cq.delete();
    e0.delete(); e1.delete();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic check_frames(input string tag);
    int f;
    chk({tag, "_nbits"}, q0.size(), e0.size());
    chk({tag, "_nbits_msb"}, q1.size(), e1.size());
    f = n_fail;
    for (int i = 0; i < e0.size() && i < q0.size() && n_fail == f; i++)
      chk($sformatf("%s_bit%0d", tag, i), 32'(q0[i]), 32'(e0[i]));
    f = n_fail;
    for (int i = 0; i < e1.size() && i < q1.size() && n_fail == f; i++)
      chk($sformatf("%s_msb_bit%0d", tag, i), 32'(q1[i]), 32'(e1[i]));
  endtask

  // Starts a pass and follows it until busy drops; optional mid-pass
  // actions fire at the given busy-cycle numbers (0 = never).
  task automatic run_pass(input int st_cyc, input int wr_cyc,
                          input logic [7:0] wv, input int clr_cyc,
                          input int mk_cyc, input logic [7:0] mv,
                          output int obc, output int ond,
                          output int oda, output int ora);
    obc = 0; ond = 0; oda = 0; ora = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < 2000 && busy; k++) begin
      obc++;
      if (done) begin ond++; oda = obc; end
      if (cclk && ora == 0) ora = obc;
      if (obc == st_cyc) start = 1'b1;
      if (obc == wr_cyc) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = wv;
      end
      if (obc == clr_cyc) refresh_en = 1'b0;
      if (obc == mk_cyc) ch_mask = mv;
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ch_mask = '0; refresh_en = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_chip_rst", crst, 0);
    chk("rst_chip_clk", cclk, 0);
    chk("rst_chip_data", cdat, 0);
    chk("rst_done_curch", {done, cur_ch}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release_pins", {busy, done, cur_ch, crst, cclk, cdat}, 0);

    // Table reads back zero after reset.
    clr();
    ch_mask = 8'h01;
    run_pass(0, 0, 8'h00, 0, 0, 8'h00, bc, nd, da, ra);
    chk("zero_busy_cycles", bc, 136);
    chk("zero_done_count", nd, 1);
    chk("zero_done_at", da, 136);
    chk("zero_first_rise", ra, 5);
    chk("zero_idle", busy, 0);
    m_pre(); m_frame(0, 8'h00); m_end();
    check_frames("zero");

    // Write ch2 in the same cycle as start.
    clr();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5; ch_mask = 8'h04;
    run_pass(0, 0, 8'h00, 0, 0, 8'h00, bc, nd, da, ra);
    chk("a5_busy_cycles", bc, 136);
    chk("a5_done_count", nd, 1);
    chk("a5_done_at", da, 136);
    chk("a5_idle", busy, 0);
    chk("a5_cur_ch_sep", 32'(cq[4]), 2);
    m_pre(); m_frame(2, 8'hA5); m_end();
    check_frames("a5");

    // Asymmetric address and data separate the two bit orders.
    clr();
    wr(3'd1, 8'h0F);
    ch_mask = 8'h02;
    run_pass(0, 0, 8'h00, 0, 0, 8'h00, bc, nd, da, ra);
    chk("ch1_busy_cycles", bc, 136);
    m_pre(); m_frame(1, 8'h0F); m_end();
    check_frames("ch1");

    // Two channels; mask change mid-pass is ignored.
    clr();
    wr(3'd0, 8'h01);
    wr(3'd7, 8'hFF);
    ch_mask = 8'h81;
    run_pass(0, 0, 8'h00, 0, 20, 8'h01, bc, nd, da, ra);
    chk("two_busy_cycles", bc, 232);
    chk("two_done_count", nd, 1);
    chk("two_done_at", da, 232);
    chk("two_cur_ch_first", 32'(cq[4]), 0);
    chk("two_cur_ch_second", 32'(cq[16]), 7);
    m_pre(); m_frame(0, 8'h01); m_frame(7, 8'hFF); m_end();
    check_frames("two");

    // Refresh: three passes, write lands in the third.
    clr();
    wr(3'd0, 8'h11);
    ch_mask = 8'h01;
    refresh_en = 1'b1;
    run_pass(0, 140, 8'h3C, 260, 0, 8'h00, bc, nd, da, ra);
    chk("refresh_busy_cycles", bc, 344);
    chk("refresh_done_count", nd, 3);
    chk("refresh_done_at", da, 344);
    chk("refresh_idle", busy, 0);
    m_pre(); m_frame(0, 8'h11); m_end();
    m_frame(0, 8'h11); m_end();
    m_frame(0, 8'h3C); m_end();
    check_frames("refresh");

    // Empty mask with a start while busy.
    clr();
    ch_mask = 8'h00;
    run_pass(10, 0, 8'h00, 0, 0, 8'h00, bc, nd, da, ra);
    chk("empty_busy_cycles", bc, 40);
    chk("empty_done_count", nd, 1);
    chk("empty_done_at", da, 40);
    m_pre(); m_end();
    check_frames("empty");

    // Reset in the middle of DATA.
    clr();
    ch_mask = 8'h04;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    chk("mid_busy_before", busy, 1);
    chk("mid_curch_before", 32'(cur_ch), 2);
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_chip_rst", crst, 0);
    chk("mid_pins", {done, cur_ch, cclk, cdat}, 0);
    chk("mid_pins_msb", {busy_m, crst_m, cclk_m, cdat_m}, 0);
    @(negedge clk);
    rst = 1'b1;

    // The table was cleared by that reset.
    clr();
    run_pass(0, 0, 8'h00, 0, 0, 8'h00, bc, nd, da, ra);
    chk("post_busy_cycles", bc, 136);
    m_pre(); m_frame(2, 8'h00); m_end();
    check_frames("post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
